// File: rtl/raster_pkg.sv
// Shared types, default screen geometry and sizing helpers for the triangle rasterizer.
package raster_pkg;

  localparam int M_DEF     = 11;
  localparam int SCR_W_DEF = 800;
  localparam int SCR_H_DEF = 600;

  typedef enum logic [2:0] {IDLE, SETUP, INIT, SCAN, CLEAR, DONE} state_t;

  typedef struct packed {
    logic signed [M_DEF-1:0] x;
    logic signed [M_DEF-1:0] y;
  } vertex_t;

  // Accumulator width that holds any edge function of M-bit screen-centred vertices.
  function automatic int edge_width(input int m);
    return 2 * (m + 2) + 2;
  endfunction

endpackage

// File: rtl/raster_edge_eval.sv
// One edge function E(P) = (Px-Ax)*(By-Ay) - (Py-Ay)*(Bx-Ax), stepped incrementally over the scan.
module raster_edge_eval
  import raster_pkg::*;
#(
  parameter int SW = 13,
  parameter int EW = edge_width(SW - 2)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_init,
  input  logic                 i_step_x,
  input  logic                 i_step_y,
  input  logic signed [SW-1:0] i_ax,
  input  logic signed [SW-1:0] i_ay,
  input  logic signed [SW-1:0] i_bx,
  input  logic signed [SW-1:0] i_by,
  input  logic signed [SW-1:0] i_px,
  input  logic signed [SW-1:0] i_py,
  output logic                 o_inside
);

  localparam int DW = SW + 1;

  logic signed [DW-1:0] w_dx, w_dy, w_rx, w_ry;
  logic signed [EW-1:0] w_e0;
  logic signed [EW-1:0] r_e, r_row_e, r_dx, r_dy;

  assign w_dx = DW'(i_bx) - DW'(i_ax);
  assign w_dy = DW'(i_by) - DW'(i_ay);
  assign w_rx = DW'(i_px) - DW'(i_ax);
  assign w_ry = DW'(i_py) - DW'(i_ay);
  assign w_e0 = EW'(w_rx) * EW'(w_dy) - EW'(w_ry) * EW'(w_dx);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_e     <= '0;
      r_row_e <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
    end else if (i_init) begin
      r_e     <= w_e0;
      r_row_e <= w_e0;
      r_dx    <= EW'(w_dx);
      r_dy    <= EW'(w_dy);
    end else if (i_step_y) begin
      r_row_e <= r_row_e - r_dx;
      r_e     <= r_row_e - r_dx;
    end else if (i_step_x) begin
      r_e <= r_e + r_dy;
    end
  end

  assign o_inside = ~r_e[EW-1];

endmodule

// File: rtl/raster_engine.sv
// Triangle rasterizer: bounding-box walk with incremental edge functions, plus framebuffer clear.
module raster_engine
  import raster_pkg::*;
#(
  parameter int M     = M_DEF,
  parameter int SCR_W = SCR_W_DEF,
  parameter int SCR_H = SCR_H_DEF,
  parameter int CW    = 8,
  parameter int AW    = $clog2(SCR_W * SCR_H),
  parameter int EW    = edge_width(M)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tri_valid,
  output logic                tri_ready,
  input  logic signed [M-1:0] v1_x,
  input  logic signed [M-1:0] v1_y,
  input  logic signed [M-1:0] v2_x,
  input  logic signed [M-1:0] v2_y,
  input  logic signed [M-1:0] v3_x,
  input  logic signed [M-1:0] v3_y,
  input  logic [CW-1:0]       tri_color,
  input  logic                clr_start,
  input  logic [CW-1:0]       clr_color,
  output logic                px_valid,
  input  logic                px_ready,
  output logic [AW-1:0]       px_addr,
  output logic [CW-1:0]       px_color,
  output logic                busy,
  output logic                tri_done
);

  localparam int SW = M + 2;
  localparam logic signed [SW-1:0] XMAX   = SW'(SCR_W - 1);
  localparam logic signed [SW-1:0] YMAX   = SW'(SCR_H - 1);
  localparam logic signed [SW-1:0] HALF_W = SW'(SCR_W / 2);
  localparam logic signed [SW-1:0] HALF_H = SW'(SCR_H / 2);
  localparam logic signed [SW-1:0] ONE    = SW'(1);
  localparam logic [AW-1:0] A_ONE     = AW'(1);
  localparam logic [AW-1:0] ROW_STEP  = AW'(SCR_W);
  localparam logic [AW-1:0] LAST_ADDR = AW'(SCR_W * SCR_H - 1);

  state_t r_state, w_next;

  logic signed [SW-1:0] r_vx [3];
  logic signed [SW-1:0] r_vy [3];
  logic [CW-1:0]        r_color;
  logic signed [SW-1:0] r_tlx, r_tly, r_brx, r_bry, r_x, r_y;
  logic [AW-1:0]        r_addr, r_row_addr;
  logic                 r_last;
  logic                 r_px_valid, r_tri_done;
  logic [AW-1:0]        r_px_addr;
  logic [CW-1:0]        r_px_color;

  logic signed [SW-1:0] w_tlx, w_tly, w_brx, w_bry;
  logic [AW-1:0]        w_tl_addr;
  logic [2:0]           w_inside;
  logic w_degen, w_clr, w_accept, w_out_free, w_walk, w_adv, w_emit;
  logic w_row_end, w_scan_end, w_init, w_step_x, w_step_y;

  function automatic logic signed [SW-1:0] min3(input logic signed [SW-1:0] a,
                                                input logic signed [SW-1:0] b,
                                                input logic signed [SW-1:0] c);
    logic signed [SW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [SW-1:0] max3(input logic signed [SW-1:0] a,
                                                input logic signed [SW-1:0] b,
                                                input logic signed [SW-1:0] c);
    logic signed [SW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic signed [SW-1:0] clampv(input logic signed [SW-1:0] v,
                                                  input logic signed [SW-1:0] hi);
    if (v[SW-1]) return '0;
    if (v > hi) return hi;
    return v;
  endfunction

  assign tri_ready = (r_state == IDLE) && !clr_start;
  assign w_clr     = (r_state == IDLE) && clr_start;
  assign w_accept  = tri_ready && tri_valid;

  assign w_tlx   = clampv(min3(r_vx[0], r_vx[1], r_vx[2]), XMAX);
  assign w_brx   = clampv(max3(r_vx[0], r_vx[1], r_vx[2]), XMAX);
  assign w_tly   = clampv(min3(r_vy[0], r_vy[1], r_vy[2]), YMAX);
  assign w_bry   = clampv(max3(r_vy[0], r_vy[1], r_vy[2]), YMAX);
  assign w_degen = (w_tlx == w_brx) || (w_tly == w_bry);
  assign w_tl_addr = AW'(r_tly) * ROW_STEP + AW'(r_tlx);

  // Scan and clear share one walk; r_last marks "all candidates issued, draining output".
  assign w_out_free = !r_px_valid || px_ready;
  assign w_walk     = ((r_state == SCAN) || (r_state == CLEAR)) && !r_last;
  assign w_adv      = w_walk && w_out_free;
  assign w_emit     = w_walk && ((r_state == CLEAR) || (&w_inside));
  assign w_row_end  = (r_x + ONE == r_brx);
  assign w_scan_end = w_row_end && (r_y + ONE == r_bry);
  assign w_init     = (r_state == INIT);
  assign w_step_x   = w_adv && (r_state == SCAN) && !w_row_end;
  assign w_step_y   = w_adv && (r_state == SCAN) && w_row_end && !w_scan_end;

  for (genvar k = 0; k < 3; k++) begin : g_edge
    raster_edge_eval #(.SW(SW), .EW(EW)) u_edge (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_init  (w_init),
      .i_step_x(w_step_x),
      .i_step_y(w_step_y),
      .i_ax    (r_vx[k]),
      .i_ay    (r_vy[k]),
      .i_bx    (r_vx[(k + 1) % 3]),
      .i_by    (r_vy[(k + 1) % 3]),
      .i_px    (r_tlx),
      .i_py    (r_tly),
      .o_inside(w_inside[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_clr)         w_next = CLEAR;
        else if (w_accept) w_next = SETUP;
      end
      SETUP:       w_next = w_degen ? DONE : INIT;
      INIT:        w_next = SCAN;
      SCAN, CLEAR: if (r_last && w_out_free) w_next = DONE;
      DONE:        w_next = IDLE;
      default:     w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vx[0] <= '0; r_vx[1] <= '0; r_vx[2] <= '0;
      r_vy[0] <= '0; r_vy[1] <= '0; r_vy[2] <= '0;
      r_color    <= '0;
      r_tlx      <= '0;
      r_tly      <= '0;
      r_brx      <= '0;
      r_bry      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_addr     <= '0;
      r_row_addr <= '0;
      r_last     <= 1'b0;
    end else begin
      if (w_clr) begin
        r_color <= clr_color;
        r_addr  <= '0;
        r_last  <= 1'b0;
      end else if (w_accept) begin
        r_color <= tri_color;
        r_vx[0] <= SW'(v1_x) + HALF_W;
        r_vy[0] <= SW'(v1_y) + HALF_H;
        r_vx[1] <= SW'(v2_x) + HALF_W;
        r_vy[1] <= SW'(v2_y) + HALF_H;
        r_vx[2] <= SW'(v3_x) + HALF_W;
        r_vy[2] <= SW'(v3_y) + HALF_H;
      end
      if (r_state == SETUP) begin
        r_tlx <= w_tlx;
        r_tly <= w_tly;
        r_brx <= w_brx;
        r_bry <= w_bry;
      end
      if (w_init) begin
        r_x        <= r_tlx;
        r_y        <= r_tly;
        r_addr     <= w_tl_addr;
        r_row_addr <= w_tl_addr;
        r_last     <= 1'b0;
      end
      if (w_adv) begin
        if (r_state == CLEAR) begin
          if (r_addr == LAST_ADDR) r_last <= 1'b1;
          else                     r_addr <= r_addr + A_ONE;
        end else if (w_scan_end) begin
          r_last <= 1'b1;
        end else if (w_row_end) begin
          r_x        <= r_tlx;
          r_y        <= r_y + ONE;
          r_row_addr <= r_row_addr + ROW_STEP;
          r_addr     <= r_row_addr + ROW_STEP;
        end else begin
          r_x    <= r_x + ONE;
          r_addr <= r_addr + A_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_px_valid <= 1'b0;
      r_px_addr  <= '0;
      r_px_color <= '0;
      r_tri_done <= 1'b0;
    end else begin
      r_tri_done <= (r_state == DONE);
      if (w_out_free) begin
        r_px_valid <= w_emit;
        if (w_emit) begin
          r_px_addr  <= r_addr;
          r_px_color <= r_color;
        end
      end
    end
  end

  assign px_valid = r_px_valid;
  assign px_addr  = r_px_addr;
  assign px_color = r_px_color;
  assign busy     = (r_state != IDLE);
  assign tri_done = r_tri_done;

endmodule

// File: tb/tb_raster_engine.sv
// Directed bench for raster_engine on a reduced 40x30 screen; expected pixels come from direct edge products.
module tb_raster_engine;
  import raster_pkg::*;

  localparam int W   = 40;
  localparam int H   = 30;
  localparam int TAW = $clog2(W * H);

  logic clk, rst;
  logic tri_valid, tri_ready;
  logic signed [M_DEF-1:0] v1_x, v1_y, v2_x, v2_y, v3_x, v3_y;
  logic [7:0] tri_color, clr_color, px_color;
  logic clr_start, px_valid, px_ready, busy, tri_done;
  logic [TAW-1:0] px_addr;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int cap_addr[$];
  int cap_col[$];
  int exp_q[$];
  bit prev_stall = 0;
  int prev_addr = 0;
  int prev_col = 0;

  raster_engine #(.M(M_DEF), .SCR_W(W), .SCR_H(H), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y), .v3_x(v3_x), .v3_y(v3_y),
    .tri_color(tri_color), .clr_start(clr_start), .clr_color(clr_color),
    .px_valid(px_valid), .px_ready(px_ready), .px_addr(px_addr), .px_color(px_color),
    .busy(busy), .tri_done(tri_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic vertex_t vtx(input int x, input int y);
    vertex_t v;
    v.x = 11'(x);
    v.y = 11'(y);
    return v;
  endfunction

  function automatic longint ef(input int ax, input int ay, input int bx, input int by,
                                input int px, input int py);
    return longint'(px - ax) * longint'(by - ay) - longint'(py - ay) * longint'(bx - ax);
  endfunction

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic build_model(input vertex_t a, input vertex_t b, input vertex_t c);
    int x0, y0, x1, y1, x2, y2, tlx, tly, brx, bry;
    x0 = int'(a.x) + W / 2;  y0 = int'(a.y) + H / 2;
    x1 = int'(b.x) + W / 2;  y1 = int'(b.y) + H / 2;
    x2 = int'(c.x) + W / 2;  y2 = int'(c.y) + H / 2;
    tlx = clampi((x0 < x1) ? ((x0 < x2) ? x0 : x2) : ((x1 < x2) ? x1 : x2), W - 1);
    brx = clampi((x0 > x1) ? ((x0 > x2) ? x0 : x2) : ((x1 > x2) ? x1 : x2), W - 1);
    tly = clampi((y0 < y1) ? ((y0 < y2) ? y0 : y2) : ((y1 < y2) ? y1 : y2), H - 1);
    bry = clampi((y0 > y1) ? ((y0 > y2) ? y0 : y2) : ((y1 > y2) ? y1 : y2), H - 1);
    exp_q.delete();
    if (tlx == brx || tly == bry) return;
    for (int y = tly; y < bry; y++)
      for (int x = tlx; x < brx; x++)
        if (ef(x0, y0, x1, y1, x, y) >= 0 && ef(x1, y1, x2, y2, x, y) >= 0 &&
            ef(x2, y2, x0, y0, x, y) >= 0)
          exp_q.push_back(y * W + x);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", px_valid, 1);
        check("hold_addr", px_addr, prev_addr);
        check("hold_color", px_color, prev_col);
      end
      if (px_valid && px_ready) begin
        cap_addr.push_back(int'(px_addr));
        cap_col.push_back(int'(px_color));
      end
      if (tri_done) done_cnt++;
      prev_stall = px_valid && !px_ready;
      prev_addr  = int'(px_addr);
      prev_col   = int'(px_color);
    end
  end

  task automatic drive_tri(input vertex_t a, input vertex_t b, input vertex_t c,
                           input logic [7:0] col);
    v1_x = a.x; v1_y = a.y; v2_x = b.x; v2_y = b.y; v3_x = c.x; v3_y = c.y;
    tri_color = col;
    tri_valid = 1'b1;
  endtask

  task automatic run_tri(input string nm, input vertex_t a, input vertex_t b, input vertex_t c,
                         input logic [7:0] col, input bit bp);
    int n;
    build_model(a, b, c);
    cap_addr.delete();
    cap_col.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    drive_tri(a, b, c, col);
    @(posedge clk); #1;
    tri_valid = 1'b0;
    for (int k = 0; k < 4000 && done_cnt == 0; k++) begin
      if (bp) px_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    px_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_done"}, done_cnt, 1);
    check({nm, "_cnt"}, cap_addr.size(), exp_q.size());
    n = (cap_addr.size() < exp_q.size()) ? cap_addr.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({nm, "_addr"}, cap_addr[i], exp_q[i]);
      check({nm, "_color"}, cap_col[i], int'(col));
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1; tri_valid = 1'b0; clr_start = 1'b0; clr_color = '0; tri_color = '0;
    px_ready = 1'b1;
    v1_x = '0; v1_y = '0; v2_x = '0; v2_y = '0; v3_x = '0; v3_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", tri_ready, 1);
    check("rst_valid", px_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", tri_done, 0);
    check("rst_addr", px_addr, 0);
    check("rst_color", px_color, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_tri("t1", vtx(0, -10), vtx(10, 10), vtx(-10, 10), 8'd5, 1'b0);
    run_tri("t1r", vtx(0, -10), vtx(-10, 10), vtx(10, 10), 8'd5, 1'b0);
    check("t1r_nonempty", exp_q.size() > 0, 1);
    run_tri("t1r_bp", vtx(0, -10), vtx(-10, 10), vtx(10, 10), 8'd5, 1'b1);

    // Degenerate: accept edge, then SETUP, DONE, and tri_done in the third cycle.
    cap_addr.delete(); cap_col.delete(); done_cnt = 0;
    @(posedge clk); #1;
    drive_tri(vtx(0, 0), vtx(5, 0), vtx(-5, 0), 8'd6);
    @(posedge clk); #1;
    tri_valid = 1'b0;
    @(negedge clk);
    check("deg_busy", busy, 1);
    check("deg_done_c1", tri_done, 0);
    @(negedge clk);
    check("deg_done_c2", tri_done, 0);
    @(negedge clk);
    check("deg_done_c3", tri_done, 1);
    check("deg_idle", busy, 0);
    repeat (2) @(negedge clk);
    check("deg_pixels", cap_addr.size(), 0);

    run_tri("clip", vtx(-500, -400), vtx(500, -400), vtx(0, 400), 8'd7, 1'b0);
    run_tri("clipr", vtx(-500, -400), vtx(0, 400), vtx(500, -400), 8'd7, 1'b0);
    check("clipr_nonempty", cap_addr.size() > 0, 1);
    foreach (cap_addr[i]) begin
      check("clip_addr_range", cap_addr[i] < W * H, 1);
      check("clip_x_edge", (cap_addr[i] % W) != W - 1, 1);
      check("clip_y_edge", (cap_addr[i] / W) != H - 1, 1);
    end

    // Clear requested together with a triangle: clear wins.
    cap_addr.delete(); cap_col.delete(); done_cnt = 0;
    @(posedge clk); #1;
    drive_tri(vtx(0, -10), vtx(-10, 10), vtx(10, 10), 8'd9);
    clr_start = 1'b1;
    clr_color = 8'd0;
    #1;
    check("clr_wins_ready", tri_ready, 0);
    @(posedge clk); #1;
    tri_valid = 1'b0;
    clr_start = 1'b0;
    cyc = 0;
    for (int k = 1; k <= W * H + 50; k++) begin
      @(negedge clk);
      if (tri_done) begin
        cyc = k;
        break;
      end
    end
    check("clr_latency", cyc, W * H + 3);
    repeat (2) @(negedge clk);
    check("clr_done_cnt", done_cnt, 1);
    check("clr_idle", busy, 0);
    check("clr_cnt", cap_addr.size(), W * H);
    foreach (cap_addr[i]) begin
      check("clr_addr", cap_addr[i], i);
      check("clr_color", cap_col[i], 0);
    end

    // Reset in the middle of a long scan.
    @(posedge clk); #1;
    drive_tri(vtx(-500, -400), vtx(0, 400), vtx(500, -400), 8'd3);
    @(posedge clk); #1;
    tri_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", px_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", tri_ready, 1);
    rst = 1'b0;
    run_tri("post_rst", vtx(0, -10), vtx(-10, 10), vtx(10, 10), 8'd9, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/raster_engine.md
Name: raster_engine

Overview:
- Synthesizable, parametrised triangle rasterizer. Successor to the team's behavioural rasterizer model.
- Accepts one triangle per valid/ready handshake and walks the clamped bounding box one pixel per cycle. Inside-test uses incremental edge functions.
- Emits framebuffer write requests (address, colour) on a valid/ready stream to the framebuffer writer.
- Adds a framebuffer-clear mode and output backpressure, which the behavioural model lacks.

Parameters:
- M, 11, signed vertex coordinate width (screen-centred coordinates).
- SCR_W, 800, screen width in pixels.
- SCR_H, 600, screen height in pixels.
- CW, 8, colour width.
- AW, $clog2(SCR_W*SCR_H), framebuffer address width.
- EW, 2*(M+2)+2, signed edge-function accumulator width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tri_valid  in  1  triangle descriptor valid
- tri_ready  out  1  engine idle and able to accept a triangle
- v1_x, v1_y, v2_x, v2_y, v3_x, v3_y  in  M each  signed vertex coordinates
- tri_color  in  CW  colour for the triangle
- clr_start  in  1  one-cycle pulse: clear the whole framebuffer; honoured only when idle
- clr_color  in  CW  fill value, sampled together with clr_start
- px_valid  out  1  pixel write request valid
- px_ready  in  1  downstream accepts the pixel
- px_addr  out  AW  y*SCR_W + x
- px_color  out  CW  pixel colour
- busy  out  1  high in every state except IDLE
- tri_done  out  1  one-cycle pulse after the last pixel of a triangle or clear is accepted, or after a degenerate triangle is dropped

Behaviour:
- Reset values: state=IDLE, tri_ready=1, px_valid=0, busy=0, tri_done=0, px_addr=0, px_color=0.
- Reset mid-operation abandons the current triangle or clear. No further pixels are emitted.
- Handshake, input side:
  - Triangle is accepted when tri_valid & tri_ready. All inputs are registered on that cycle.
  - tri_ready=1 only in IDLE.
  - clr_start in the same cycle as tri_valid: clear wins, and tri_ready is 0 that cycle.
- Handshake, output side: px_* hold stable while px_valid & !px_ready. The scan does not advance while stalled.
- FSM:
  - IDLE -> SETUP on triangle accept.
  - IDLE -> CLEAR on clr_start.
- SETUP (1 cycle):
  - Screen coords: Vx = v + SCR_W/2, Vy = v + SCR_H/2, signed, width M+2.
  - Bounding box: TL = per-axis minimum of the three vertices, BR = per-axis maximum.
  - Clamp every TL/BR component to [0, SCR_W-1] (x) and [0, SCR_H-1] (y).
  - If TL_x==BR_x or TL_y==BR_y, the triangle is degenerate: go to DONE without emitting pixels.
  - Otherwise go to INIT.
- INIT (1 cycle):
  - Compute E_k at pixel (TL_x, TL_y) for the edges V1->V2, V2->V3, V3->V1.
  - E(P) = (Px-Ax)*(By-Ay) - (Py-Ay)*(Bx-Ax), full EW-bit signed.
  - Store the per-edge step values dy_k = By-Ay and dx_k = Bx-Ax. Store the row-start copies of E_k.
  - Go to SCAN.
- SCAN:
  - Visits x in [TL_x, BR_x) and y in [TL_y, BR_y). BR is exclusive, matching the behavioural model.
  - Order is row-major. Advances one pixel per cycle when the output register is free.
  - Pixel is inside iff all three E_k >= 0. Inside pixels produce px_valid with px_color = latched colour. Outside pixels produce no output.
  - Step along x: E_k += dy_k. New row: row_E_k -= dx_k, and E_k is reloaded from row_E_k.
  - Address is kept incrementally: +1 per x, row base += SCR_W per row. No multiplier in the scan loop.
  - After the last pixel is accepted, go to DONE.
- CLEAR:
  - Emits addresses 0 .. SCR_W*SCR_H-1 in order with px_color = clr_color.
  - One address per cycle when px_ready is held high. Then go to DONE.
- DONE: pulse tri_done for 1 cycle, then go to IDLE.
- Throughput with px_ready held high: one candidate pixel per cycle.
- Latency: accept -> first candidate pixel = 3 cycles (SETUP, INIT, first SCAN).
- Arithmetic: all edge math is signed, and the EW width guarantees no overflow for any M-bit input.

Decomposition:
- raster_pkg:
  - fsm state enum (IDLE, SETUP, INIT, SCAN, CLEAR, DONE);
  - screen-size localparams;
  - edge-function width helper;
  - vertex struct (x, y signed M).
- Sub-module raster_edge_eval: one instance per edge.
  - Holds E_k and row_E_k.
  - Controls: init, step_x, step_y.
  - Output: inside flag.

Test Plan:
- V1=(0,-10), V2=(10,10), V3=(-10,10), colour 5, px_ready=1:
  - bbox x 390..410, y 290..310;
  - emitted pixel set must equal the behavioural model's set, all colour 5;
  - tri_done pulses after the last pixel.
- Degenerate triangle V1=(0,0), V2=(5,0), V3=(-5,0) -> zero pixels emitted, tri_done 3 cycles after accept.
- Off-screen clamp V1=(-500,-400), V2=(500,-400), V3=(0,400) -> every px_addr < 480000; x never reaches 799, y never reaches 599.
- Backpressure: same triangle as test 1, px_ready toggled randomly -> identical pixel sequence, px_* stable during stalls, no drops or duplicates.
- clr_start with clr_color=0 -> exactly 480000 writes, addresses 0..479999 ascending, then tri_done.
- Reset asserted mid-SCAN -> next cycle px_valid=0, busy=0, tri_ready=1; a subsequent triangle rasterizes correctly.
